count_run_ctrl: RTL and testbench

Run-control sequencer for the 4-digit BCD counter/display chain. It debounces two push-buttons (start/stop, lap/clear) and runs a stopwatch FSM. The FSM gates the slow tick into a count-enable strobe, issues counter clears, and freezes the display for lap readout. It sits between the tick generator and the digit counter, and drives the hold input of the display path.

---
 rtl/count_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_count_run_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_run_ctrl.sv
// count_run_ctrl
//   Run-control sequencer for the 4-digit BCD stopwatch chain. Debounces the
//   start/stop and lap/clear buttons, runs the stopwatch FSM, gates the slow
//   tick into a count-enable strobe, issues counter clears and freezes the
//   display while a lap time is shown.
//
// Ports
//   clk_100MHz      in   system clock, sole domain
//   reset           in   synchronous active-high reset
//   btn_start_stop  in   raw asynchronous button, active-high
//   btn_lap_clear   in   raw asynchronous button, active-high
//   tick            in   single-cycle strobe from the tick generator
//   at_max          in   counter digits read 9999
//   count_en        out  single-cycle increment strobe to the counter
//   count_clr       out  single-cycle clear strobe to the counter
//   disp_hold       out  display keeps its last value while high
//   state           out  registered FSM state
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | stopped at zero / after clear, ticks ignored
// RUN   | ticks forwarded to the counter
// PAUSE | stopped, value kept, ticks ignored
// LAP   | counting continues, display frozen for lap readout

module count_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int STOP_AT_MAX     = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       tick,
  input  logic       at_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // index 0 = start/stop, index 1 = lap/clear
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db_level;
  logic [1:0]       press;
  logic [CNT_W-1:0] db_cnt [2];

  logic [1:0] state_q;
  logic [1:0] state_next;
  logic       en_next;
  logic       clr_next;
  logic       ss_p;
  logic       lc_p;
  logic       auto_pause;
  logic       counting;

  assign btn_raw = {btn_lap_clear, btn_start_stop};

  // Debounce: the counter only runs while the synchronized level disagrees
  // with the accepted level; any agreement restarts the interval.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
          press[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_q;
    en_next    = 1'b0;
    clr_next   = 1'b0;
    ss_p       = press[0];
    lc_p       = press[1] & ~press[0];
    counting   = (state_q == RUN) || (state_q == LAP);
    // A tick that would take the counter past 9999 pauses instead of counting.
    auto_pause = (STOP_AT_MAX != 0) && tick && at_max && counting;

    case (state_q)
      IDLE: begin
        if (ss_p)      state_next = RUN;
        else if (lc_p) clr_next   = 1'b1;
      end
      RUN: begin
        if (ss_p || auto_pause) state_next = PAUSE;
        else if (lc_p)          state_next = LAP;
      end
      LAP: begin
        if (ss_p || auto_pause) state_next = PAUSE;
        else if (lc_p)          state_next = RUN;
      end
      PAUSE: begin
        if (ss_p) begin
          state_next = RUN;
        end else if (lc_p) begin
          state_next = IDLE;
          clr_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // State is sampled before the transition, so a tick on the exit press
    // still counts and a tick on the entry press does not.
    en_next = counting && tick && !auto_pause && !clr_next;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_next;
      count_en  <= en_next;
      count_clr <= clr_next;
      disp_hold <= (state_q == LAP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
module tb_count_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss;
  logic       lc;
  logic       tick;
  logic       at_max;
  logic       en0, clr0, hold0;
  logic       en1, clr1, hold1;
  logic [1:0] st0, st1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .STOP_AT_MAX(1)) u0 (
    .clk_100MHz(clk), .reset(reset), .btn_start_stop(ss), .btn_lap_clear(lc),
    .tick(tick), .at_max(at_max), .count_en(en0), .count_clr(clr0),
    .disp_hold(hold0), .state(st0));

  count_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .STOP_AT_MAX(0)) u1 (
    .clk_100MHz(clk), .reset(reset), .btn_start_stop(ss), .btn_lap_clear(lc),
    .tick(tick), .at_max(at_max), .count_en(en1), .count_clr(clr1),
    .disp_hold(hold1), .state(st1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises the chosen button(s) and stops right after the edge on which the
  // FSM acts on the press (2 sync + 4 debounce + 1 register = 7 edges).
  task automatic press_btn(input logic do_ss, input logic do_lc);
    ss = do_ss;
    lc = do_lc;
    repeat (7) step();
  endtask

  // Releases and waits until the release has been debounced.
  task automatic release_btn();
    ss = 1'b0;
    lc = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; ss = 0; lc = 0; tick = 0; at_max = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_cmp++;
    if ({st0, en0, clr0, hold0} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_u0: got %b want 00000", {st0, en0, clr0, hold0});
    end
    n_cmp++;
    if ({st1, en1, clr1, hold1} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_u1: got %b want 00000", {st1, en1, clr1, hold1});
    end
  endtask

  task automatic test_glitch();
    ss = 1'b1;
    repeat (3) step();
    ss = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (st0 !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_state: got %b want 00", st0);
    end
  endtask

  task automatic test_press_latency();
    ss = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 6) begin
        n_cmp++;
        if (st0 !== 2'b00) begin
          n_err++;
          $display("FAIL latency_early: got %b want 00 at cycle 6", st0);
        end
      end
    end
    n_cmp++;
    if (st0 !== 2'b01) begin
      n_err++;
      $display("FAIL latency_run: got %b want 01 at cycle 7", st0);
    end
    repeat (3) step();
    release_btn();
    n_cmp++;
    if (st0 !== 2'b01) begin
      n_err++;
      $display("FAIL release_no_press: got %b want 01", st0);
    end
  endtask

  task automatic test_tick_run();
    int pulses = 0;
    for (int c = 0; c < 50; c++) begin
      tick = (c % 10 == 0);
      step();
      if (en0) pulses++;
      if (c % 10 == 0 || c % 10 == 1) begin
        n_cmp++;
        if (en0 !== (c % 10 == 0)) begin
          n_err++;
          $display("FAIL tick_en c=%0d: got %b want %b", c, en0, (c % 10 == 0));
        end
      end
    end
    tick = 1'b0;
    n_cmp++;
    if (pulses != 5) begin
      n_err++;
      $display("FAIL tick_count: got %0d want 5", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      seen[i] = en0;
    end
    tick = 1'b0;
    step();
    seen[3] = en0;
    n_cmp++;
    if (seen !== 4'b0111) begin
      n_err++;
      $display("FAIL back_to_back: got %b want 0111", seen);
    end
  endtask

  task automatic test_pause();
    press_btn(1'b1, 1'b0);
    n_cmp++;
    if (st0 !== 2'b10) begin
      n_err++;
      $display("FAIL pause_state: got %b want 10", st0);
    end
    release_btn();
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_cmp++;
    if (en0 !== 1'b0) begin
      n_err++;
      $display("FAIL pause_no_en: got %b want 0", en0);
    end
  endtask

  task automatic test_lap();
    press_btn(1'b1, 1'b0);
    release_btn();
    press_btn(1'b0, 1'b1);
    n_cmp++;
    if (st0 !== 2'b11 || hold0 !== 1'b0) begin
      n_err++;
      $display("FAIL lap_enter: got st=%b hold=%b want st=11 hold=0", st0, hold0);
    end
    step();
    n_cmp++;
    if (hold0 !== 1'b1) begin
      n_err++;
      $display("FAIL lap_hold: got %b want 1", hold0);
    end
    release_btn();
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_cmp++;
    if (en0 !== 1'b1) begin
      n_err++;
      $display("FAIL lap_count: got %b want 1", en0);
    end
    press_btn(1'b0, 1'b1);
    n_cmp++;
    if (st0 !== 2'b01) begin
      n_err++;
      $display("FAIL lap_exit: got %b want 01", st0);
    end
    step();
    n_cmp++;
    if (hold0 !== 1'b0) begin
      n_err++;
      $display("FAIL lap_hold_drop: got %b want 0", hold0);
    end
    release_btn();
  endtask

  task automatic test_clear();
    press_btn(1'b1, 1'b0);
    release_btn();
    press_btn(1'b0, 1'b1);
    n_cmp++;
    if ({st0, clr0, en0} !== 4'b0010) begin
      n_err++;
      $display("FAIL clear_pause: got st,clr,en=%b want 0010", {st0, clr0, en0});
    end
    step();
    n_cmp++;
    if (clr0 !== 1'b0) begin
      n_err++;
      $display("FAIL clear_width: got %b want 0", clr0);
    end
    release_btn();
    press_btn(1'b0, 1'b1);
    n_cmp++;
    if ({st0, clr0} !== 3'b001) begin
      n_err++;
      $display("FAIL clear_idle: got st,clr=%b want 001", {st0, clr0});
    end
    release_btn();
  endtask

  task automatic test_at_max();
    press_btn(1'b1, 1'b0);
    release_btn();
    at_max = 1'b1;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    at_max = 1'b0;
    n_cmp++;
    if (en0 !== 1'b0 || st0 !== 2'b10) begin
      n_err++;
      $display("FAIL stop_at_max1: got en=%b st=%b want en=0 st=10", en0, st0);
    end
    n_cmp++;
    if (en1 !== 1'b1 || st1 !== 2'b01) begin
      n_err++;
      $display("FAIL stop_at_max0: got en=%b st=%b want en=1 st=01", en1, st1);
    end
  endtask

  task automatic test_simultaneous();
    press_btn(1'b1, 1'b0);
    release_btn();
    press_btn(1'b1, 1'b1);
    step();
    n_cmp++;
    if (st0 !== 2'b10 || hold0 !== 1'b0) begin
      n_err++;
      $display("FAIL simul_press: got st=%b hold=%b want st=10 hold=0", st0, hold0);
    end
    release_btn();
  endtask

  task automatic test_reset_in_lap();
    press_btn(1'b1, 1'b0);
    release_btn();
    press_btn(1'b0, 1'b1);
    release_btn();
    n_cmp++;
    if (st0 !== 2'b11 || hold0 !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_lap: got st=%b hold=%b want st=11 hold=1", st0, hold0);
    end
    ss = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({st0, en0, clr0, hold0} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_in_lap: got %b want 00000", {st0, en0, clr0, hold0});
    end
    ss    = 1'b0;
    reset = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (st0 !== 2'b00) begin
      n_err++;
      $display("FAIL reset_discard: got %b want 00", st0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_latency();
    test_tick_run();
    test_back_to_back();
    test_pause();
    test_lap();
    test_clear();
    test_at_max();
    test_simultaneous();
    test_reset_in_lap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
